mac_tx_rgmii: RTL and testbench



---
 rtl/mac_pkg.sv | 26 ++
 rtl/mac_tx_ddr_out.sv | 34 +++
 rtl/mac_tx_rgmii.sv | 149 ++++++++++++++
 tb/tb_mac_tx_rgmii.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types, CRC-32 constants and the bytewise CRC update used by the
// Ethernet transmit MAC.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        FCS  = 2'd2,
        IFG  = 2'd3
    } state_t;

    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

    // Reflected CRC-32, one byte per call, data consumed LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/mac_tx_ddr_out.sv
// Behavioural same-edge ODDR: both halves captured on the rising edge, rise
// value driven while clk is high, fall value while clk is low.
module mac_tx_ddr_out #(
    parameter logic INIT_RISE = 1'b0,
    parameter logic INIT_FALL = 1'b0
) (
    input  logic clk,
    input  logic srst,
    input  logic d_rise,
    input  logic d_fall,
    output logic q
);

    logic rise_q, rise_d;
    logic fall_q, fall_d;

    always_comb begin
        rise_d = d_rise;
        fall_d = d_fall;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rise_q <= INIT_RISE;
            fall_q <= INIT_FALL;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign q = clk ? rise_q : fall_q;

endmodule

// File: rtl/mac_tx_rgmii.sv
// Gigabit transmit MAC: forwards caller-built preamble and body bytes, appends
// the CRC-32 FCS, enforces the inter-frame gap and drives RGMII through ODDRs.
module mac_tx_rgmii
    import mac_pkg::*;
#(
    parameter int PREAMBLE_LEN = 8,
    parameter int IFG_CYCLES   = 12,
    parameter int MAX_BYTES    = 1530
) (
    input  logic       clk,
    input  logic       Reset_i,
    input  logic       Trig_i,
    input  logic [7:0] Data_in,
    input  logic       Last_byte,
    output logic       Data_Strobe,
    output logic       Busy,
    output logic       PHY_TXEN_o,
    output logic       PHY_GTXCLK_o,
    output logic [3:0] PHY_TXD_o
);

    localparam int CNT_W = $clog2(MAX_BYTES + 1);
    localparam int IFG_W = $clog2(IFG_CYCLES + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       fcs_idx_q, fcs_idx_d;
    logic [IFG_W-1:0] ifg_cnt_q, ifg_cnt_d;
    logic [31:0]      crc_q, crc_d;
    logic [7:0]       byte_q, byte_d;
    logic             txen_q, txen_d;
    logic [31:0]      fcs;
    logic             end_of_body;

    assign fcs         = ~crc_q;
    // A frame that hits the byte limit is closed on its final allowed byte.
    assign end_of_body = Last_byte || (cnt_q == CNT_W'(MAX_BYTES - 1));

    assign Data_Strobe = (state_q == DATA);
    assign Busy        = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fcs_idx_d = fcs_idx_q;
        ifg_cnt_d = ifg_cnt_q;
        crc_d     = crc_q;
        byte_d    = 8'h00;
        txen_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (Trig_i) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    crc_d   = CRC_INIT;
                end
            end
            DATA: begin
                byte_d = Data_in;
                txen_d = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q >= CNT_W'(PREAMBLE_LEN)) begin
                    crc_d = crc32_byte(crc_q, Data_in);
                end
                if (end_of_body) begin
                    state_d   = FCS;
                    fcs_idx_d = 2'd0;
                end
            end
            FCS: begin
                byte_d    = fcs[{fcs_idx_q, 3'b000} +: 8];
                txen_d    = 1'b1;
                fcs_idx_d = fcs_idx_q + 2'd1;
                if (fcs_idx_q == 2'd3) begin
                    state_d   = IFG;
                    ifg_cnt_d = '0;
                end
            end
            IFG: begin
                ifg_cnt_d = ifg_cnt_q + 1'b1;
                if (ifg_cnt_q == IFG_W'(IFG_CYCLES - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            fcs_idx_q <= 2'd0;
            ifg_cnt_q <= '0;
            crc_q     <= CRC_INIT;
            byte_q    <= 8'h00;
            txen_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fcs_idx_q <= fcs_idx_d;
            ifg_cnt_q <= ifg_cnt_d;
            crc_q     <= crc_d;
            byte_q    <= byte_d;
            txen_q    <= txen_d;
        end
    end

    // Low nibble on the clk-high half, high nibble on the clk-low half.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_txd
            mac_tx_ddr_out #(
                .INIT_RISE (1'b0),
                .INIT_FALL (1'b0)
            ) u_txd (
                .clk    (clk),
                .srst   (Reset_i),
                .d_rise (byte_q[gi]),
                .d_fall (byte_q[gi+4]),
                .q      (PHY_TXD_o[gi])
            );
        end
    endgenerate

    mac_tx_ddr_out #(
        .INIT_RISE (1'b0),
        .INIT_FALL (1'b0)
    ) u_txen (
        .clk    (clk),
        .srst   (Reset_i),
        .d_rise (txen_q),
        .d_fall (txen_q),
        .q      (PHY_TXEN_o)
    );

    mac_tx_ddr_out #(
        .INIT_RISE (1'b1),
        .INIT_FALL (1'b0)
    ) u_gtxclk (
        .clk    (clk),
        .srst   (Reset_i),
        .d_rise (1'b1),
        .d_fall (1'b0),
        .q      (PHY_GTXCLK_o)
    );

endmodule

// File: tb/tb_mac_tx_rgmii.sv
// Bench for mac_tx_rgmii: scoreboard of expected PHY bytes (with arrival
// cycle), table of known CRC-32 vectors, and hand-written corner sequences.
module tb_mac_tx_rgmii;

    localparam int IFG_CYCLES = 12;
    localparam int MAX_BYTES  = 1530;

    logic       clk = 1'b0;
    logic       Reset_i = 1'b1;
    logic       Trig_i = 1'b0;
    logic [7:0] Data_in = 8'h00;
    logic       Last_byte = 1'b0;
    logic       Data_Strobe;
    logic       Busy;
    logic       PHY_TXEN_o;
    logic       PHY_GTXCLK_o;
    logic [3:0] PHY_TXD_o;

    mac_tx_rgmii #(
        .PREAMBLE_LEN (8),
        .IFG_CYCLES   (IFG_CYCLES),
        .MAX_BYTES    (MAX_BYTES)
    ) dut (
        .clk          (clk),
        .Reset_i      (Reset_i),
        .Trig_i       (Trig_i),
        .Data_in      (Data_in),
        .Last_byte    (Last_byte),
        .Data_Strobe  (Data_Strobe),
        .Busy         (Busy),
        .PHY_TXEN_o   (PHY_TXEN_o),
        .PHY_GTXCLK_o (PHY_GTXCLK_o),
        .PHY_TXD_o    (PHY_TXD_o)
    );

    always #4 clk = ~clk;

    typedef struct packed {
        logic [7:0] b;
        int         cyc;
    } exp_t;

    typedef logic [63:0][7:0] body_t;
    typedef struct packed {
        body_t       body;
        logic [7:0]  len;
        logic [31:0] crc;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    exp_t       exp_q[$];
    logic [7:0] frame_q[$];
    logic [7:0] rx_q[$];
    logic [3:0] rx_hi_q[$];
    logic [3:0] rx_lo_q[$];

    int frames_done   = 0;
    int last_run      = 0;
    int run_len       = 0;
    int idle_len      = 0;
    int last_idle     = 0;
    int busy_low      = 0;
    int last_busy_low = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Bit-serial reference CRC register update (no final complement).
    function automatic logic [31:0] crc_step(input logic [31:0] r, input logic [7:0] b);
        logic [31:0] x;
        logic        fb;
        x = r;
        for (int k = 0; k < 8; k++) begin
            fb = x[0] ^ b[k];
            x  = {1'b0, x[31:1]} ^ (fb ? 32'hEDB8_8320 : 32'h0);
        end
        return x;
    endfunction

    function automatic logic [31:0] model_fcs();
        logic [31:0] r;
        r = 32'hFFFF_FFFF;
        for (int k = 8; k < frame_q.size(); k++) r = crc_step(r, frame_q[k]);
        return ~r;
    endfunction

    function automatic vec_t mk_vec(input string s, input logic [31:0] crc);
        vec_t v;
        v.body = '0;
        v.len  = 8'(s.len());
        for (int k = 0; k < s.len(); k++) v.body[k] = s[k];
        v.crc  = crc;
        return v;
    endfunction

    task automatic load_preamble();
        frame_q.delete();
        for (int k = 0; k < 7; k++) frame_q.push_back(8'h55);
        frame_q.push_back(8'hD5);
    endtask

    task automatic load_vec(input vec_t v);
        load_preamble();
        for (int k = 0; k < int'(v.len); k++) frame_q.push_back(v.body[k]);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        busy_low <= (Busy === 1'b0) ? busy_low + 1 : 0;
        if (Busy === 1'b1 && busy_low > 0) last_busy_low <= busy_low;
    end

    // PHY monitor: sample each half a little after its clock edge.
    logic       s_en_hi, s_gclk_hi, prev_en;
    logic [3:0] s_txd_hi;
    logic [7:0] rx_b;
    int         s_cyc;
    exp_t       e_mon;
    initial prev_en = 1'b0;
    always begin
        @(posedge clk); #2;
        s_en_hi   = PHY_TXEN_o;
        s_txd_hi  = PHY_TXD_o;
        s_gclk_hi = PHY_GTXCLK_o;
        s_cyc     = cyc;
        @(negedge clk); #2;
        check("gtxclk_high_half", 32'(s_gclk_hi), 32'd1);
        check("gtxclk_low_half", 32'(PHY_GTXCLK_o), 32'd0);
        check("txen_both_halves", 32'(PHY_TXEN_o), 32'(s_en_hi));
        if (s_en_hi === 1'b1) begin
            rx_b = {PHY_TXD_o, s_txd_hi};
            rx_q.push_back(rx_b);
            rx_hi_q.push_back(s_txd_hi);
            rx_lo_q.push_back(PHY_TXD_o);
            if (prev_en !== 1'b1) last_idle = idle_len;
            run_len++;
            check("byte_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e_mon = exp_q.pop_front();
                check("tx_byte", 32'(rx_b), 32'(e_mon.b));
                check("tx_cycle", 32'(s_cyc), 32'(e_mon.cyc));
            end
        end else begin
            if (prev_en === 1'b1) begin
                last_run = run_len;
                run_len  = 0;
                idle_len = 1;
                frames_done++;
            end else begin
                idle_len++;
            end
        end
        prev_en = s_en_hi;
    end

    // Feed frame_q on the strobe; expected bytes land on the PHY two edges
    // after being driven (one register stage, one DDR launch).
    task automatic send_frame(input logic [31:0] fcs, input bit hold_trig,
                              input bit assert_last, input string tag);
        int   wd;
        int   fd0;
        exp_t e;
        fd0 = frames_done;
        rx_q.delete();
        rx_hi_q.delete();
        rx_lo_q.delete();
        Trig_i = 1'b1;
        for (int i = 0; i < frame_q.size(); i++) begin
            wd = 0;
            while (Data_Strobe !== 1'b1 && wd < 40) begin
                @(negedge clk);
                wd++;
            end
            if (Data_Strobe !== 1'b1) begin
                check({tag, "_strobe_wait"}, 32'(Data_Strobe), 32'd1);
                break;
            end
            if (!hold_trig) Trig_i = 1'b0;
            Data_in   = frame_q[i];
            Last_byte = assert_last && (i == frame_q.size() - 1);
            e.b   = frame_q[i];
            e.cyc = cyc + 2;
            exp_q.push_back(e);
            if (i == frame_q.size() - 1) begin
                for (int k = 0; k < 4; k++) begin
                    e.b   = fcs[8*k +: 8];
                    e.cyc = e.cyc + 1;
                    exp_q.push_back(e);
                end
            end
            @(negedge clk);
        end
        Data_in   = 8'h00;
        Last_byte = 1'b0;
        check({tag, "_strobe_drop"}, 32'(Data_Strobe), 32'd0);
        wd = 0;
        while (frames_done == fd0 && wd < 40) begin
            @(negedge clk);
            wd++;
        end
        check({tag, "_frame_end"}, 32'(frames_done != fd0), 32'd1);
        check({tag, "_txen_len"}, 32'(last_run), 32'(frame_q.size() + 4));
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
        $display("frame %s: %0d bytes fed, %0d bytes on PHY, fcs %h", tag,
                 frame_q.size(), rx_q.size(), fcs);
    endtask

    vec_t       vecs[5];
    logic [7:0] hdr[26];
    logic [31:0] r;
    int          wd;

    initial begin
        vecs[0] = mk_vec("", 32'h0000_0000);
        vecs[1] = mk_vec("a", 32'hE8B7_BE43);
        vecs[2] = mk_vec("abc", 32'h3524_41C2);
        vecs[3] = mk_vec("123456789", 32'hCBF4_3926);
        vecs[4] = mk_vec("The quick brown fox jumps over the lazy dog", 32'h414F_A339);

        // Reset held with Trig_i high: nothing may start.
        Reset_i = 1'b1;
        Trig_i  = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk); #1;
            check("reset_quiet", {29'h0, Busy, Data_Strobe, PHY_TXEN_o}, 32'h0);
        end
        @(negedge clk);
        Reset_i = 1'b0;
        check("reset_busy_release", 32'(Busy), 32'd0);
        @(negedge clk);
        check("trig_busy", 32'(Busy), 32'd1);
        check("trig_strobe", 32'(Data_Strobe), 32'd1);
        load_vec(vecs[3]);
        send_frame(vecs[3].crc, 1'b0, 1'b1, "after_reset");

        for (int v = 0; v < 5; v++) begin
            load_vec(vecs[v]);
            send_frame(vecs[v].crc, 1'b0, 1'b1, $sformatf("vec%0d", v));
        end

        // Nibble order on a lone A5 body byte.
        load_preamble();
        frame_q.push_back(8'hA5);
        send_frame(model_fcs(), 1'b0, 1'b1, "nibble");
        check("nibble_high_half", 32'(rx_hi_q[8]), 32'h5);
        check("nibble_low_half", 32'(rx_lo_q[8]), 32'hA);

        // Full 59-byte frame, residue over body+FCS.
        hdr = '{8'h4B, 8'h45, 8'h59, 8'h00, 8'h00, 8'h01,
                8'h3C, 8'h97, 8'h0E, 8'h38, 8'h46, 8'hF0,
                8'h00, 8'h0C,
                8'h42, 8'h01, 8'h80, 8'h00, 8'h00, 8'h04,
                8'h00, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00};
        load_preamble();
        foreach (hdr[k]) frame_q.push_back(hdr[k]);
        while (frame_q.size() < 59) frame_q.push_back(8'h00);
        send_frame(model_fcs(), 1'b0, 1'b1, "full");
        check("full_phy_bytes", 32'(rx_q.size()), 32'd63);
        r = 32'hFFFF_FFFF;
        for (int k = 8; k < rx_q.size(); k++) r = crc_step(r, rx_q[k]);
        check("full_residue", r, mac_pkg::CRC_RESIDUE);

        // Back-to-back frames with Trig_i held high.
        load_vec(vecs[2]);
        send_frame(vecs[2].crc, 1'b1, 1'b1, "retrig_a");
        send_frame(vecs[2].crc, 1'b0, 1'b1, "retrig_b");
        check("retrig_ifg_ge", 32'(last_idle >= IFG_CYCLES), 32'd1);
        check("retrig_busy_low", 32'(last_busy_low), 32'd1);

        // Reset mid-payload: the in-flight byte and the FCS must vanish.
        load_preamble();
        for (int k = 0; k < 32; k++) frame_q.push_back(8'(k * 3 + 1));
        Trig_i = 1'b1;
        wd = 0;
        while (Data_Strobe !== 1'b1 && wd < 40) begin
            @(negedge clk);
            wd++;
        end
        check("abort_strobe_wait", 32'(Data_Strobe), 32'd1);
        Trig_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back('{b: frame_q[i], cyc: cyc + 2});
            Data_in = frame_q[i];
            @(negedge clk);
        end
        Reset_i = 1'b1;
        Data_in = 8'h00;
        while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
        @(negedge clk); #1;
        check("abort_txen", 32'(PHY_TXEN_o), 32'd0);
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_strobe", 32'(Data_Strobe), 32'd0);
        repeat (4) @(negedge clk);
        Reset_i = 1'b0;
        check("abort_sb_empty", 32'(exp_q.size()), 32'd0);
        load_vec(vecs[3]);
        send_frame(vecs[3].crc, 1'b0, 1'b1, "after_abort");

        // No Last_byte at all: closed at MAX_BYTES.
        load_preamble();
        while (frame_q.size() < MAX_BYTES) frame_q.push_back(8'(frame_q.size() * 7));
        send_frame(model_fcs(), 1'b0, 1'b0, "force_end");

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
